tx_wr_arb: RTL and testbench

TX_WR_ARB -- requirements
Module: tx_wr_arb

---
 rtl/tx_wr_arb.sv | 102 ++++++++++
 tb/tb_tx_wr_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_wr_arb.sv
// rtl/tx_wr_arb.sv - two-requester round-robin write arbiter in front of an async FIFO write port
// Bursting is compiled in by defining TX_WR_ARB_BURST_EN; otherwise each grant lasts one beat.
module tx_wr_arb #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             wrt_clk,
  input  logic             wrst_n,
  input  logic             m0_valid,
  input  logic [DSIZE-1:0] m0_data,
  output logic             m0_ready,
  input  logic             m1_valid,
  input  logic [DSIZE-1:0] m1_data,
  output logic             m1_ready,
  input  logic             wfull,
  output logic             wrt_en,
  output logic [DSIZE-1:0] wdata,
  output logic             gnt_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   own_valid, other_valid, burst_done;
  state_e other_state;

`ifdef TX_WR_ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;

  assign burst_done = ((cnt_q + 4'd1) == 4'(BURST_LEN));

  // Counter advances only on accepted beats; a full FIFO freezes it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!wfull) begin
      if (own_valid && !burst_done) cnt_d = cnt_q + 4'd1;
      else                          cnt_d = '0;
    end
  end

  always_ff @(posedge wrt_clk or negedge wrst_n) begin
    if (!wrst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  // Without bursting every accepted beat ends the grant.
  localparam int EFF_BURST = BURST_LEN - BURST_LEN + 1;
  assign burst_done = (EFF_BURST == 1);
`endif

  always_comb begin
    own_valid   = (state_q == OWN1) ? m1_valid : m0_valid;
    other_valid = (state_q == OWN1) ? m0_valid : m1_valid;
    other_state = (state_q == OWN1) ? OWN0 : OWN1;
  end

  assign m0_ready = (state_q == OWN0) & ~wfull;
  assign m1_ready = (state_q == OWN1) & ~wfull;
  assign wrt_en   = (((state_q == OWN0) & m0_valid) | ((state_q == OWN1) & m1_valid)) & ~wfull;
  assign wdata    = (state_q == OWN0) ? m0_data : (state_q == OWN1) ? m1_data : '0;
  assign gnt_id   = (state_q == OWN1);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) state_d = last_gnt_q ? OWN0 : OWN1;
        else if (m0_valid)        state_d = OWN0;
        else if (m1_valid)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!wfull) begin
          if (!own_valid)                     state_d = other_valid ? other_state : IDLE;
          else if (burst_done && other_valid) state_d = other_state;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_d == OWN0)      last_gnt_d = 1'b0;
    else if (state_d == OWN1) last_gnt_d = 1'b1;
  end

  always_ff @(posedge wrt_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_tx_wr_arb.sv
// tb/tb_tx_wr_arb.sv - randomized and directed bench for tx_wr_arb against a grant-level reference model
module tb_tx_wr_arb;
  localparam int DSIZE = 8;
  localparam int BL    = 4;
`ifdef TX_WR_ARB_BURST_EN
  localparam int EBL = BL;
`else
  localparam int EBL = 1;
`endif

  logic             wrt_clk = 1'b0;
  logic             wrst_n  = 1'b0;
  logic             m0_valid = 1'b0, m1_valid = 1'b0, wfull = 1'b0;
  logic [DSIZE-1:0] m0_data = '0, m1_data = '0;
  logic             m0_ready, m1_ready, wrt_en, gnt_id, busy;
  logic [DSIZE-1:0] wdata;

  tx_wr_arb #(.DSIZE(DSIZE), .BURST_LEN(BL)) dut (
    .wrt_clk(wrt_clk), .wrst_n(wrst_n),
    .m0_valid(m0_valid), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_data(m1_data), .m1_ready(m1_ready),
    .wfull(wfull), .wrt_en(wrt_en), .wdata(wdata), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 wrt_clk = ~wrt_clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source queues (what still has to be offered) and expected FIFO-side sequences
  logic [7:0] q0[$], q1[$], e0[$], e1[$];
  bit hold0 = 0, hold1 = 0;
  int log_id[$], log_dat[$], log_cyc[$];
  int cyc = 0;
  logic s_wen, s_r1, s_gnt, s_busy;

  // Reference model: owner (-1 idle), beats in the current grant, last owner
  int m_own = -1, m_cnt = 0, m_last = 1;

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1;
  endtask

  task automatic model_step(input bit v0, input bit v1, input bit wf);
    int o;
    bit vo, vx;
    o = m_own;
    if (o < 0) begin
      m_cnt = 0;
      if (v0 && v1) m_own = 1 - m_last;
      else if (v0)  m_own = 0;
      else if (v1)  m_own = 1;
    end else if (!wf) begin
      vo = (o == 0) ? v0 : v1;
      vx = (o == 0) ? v1 : v0;
      if (!vo) begin
        m_cnt = 0;
        m_own = vx ? 1 - o : -1;
      end else begin
        m_cnt++;
        if (m_cnt == EBL) begin
          m_cnt = 0;
          if (vx) m_own = 1 - o;
        end
      end
    end
    if (m_own >= 0) m_last = m_own;
  endtask

  task automatic push(input int r, input logic [7:0] d);
    if (r == 0) begin q0.push_back(d); e0.push_back(d); end
    else        begin q1.push_back(d); e1.push_back(d); end
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    hold0 = 0; hold1 = 0;
    log_id.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  // One clock: drive just after posedge, check at negedge, advance model
  task automatic cycle(input bit en0, input bit en1, input bit wf);
    bit er0, er1, ewe, egnt, ebusy;
    logic [7:0] ewd, exp_d;
    if (!hold0) m0_valid = en0 && (q0.size() > 0);
    if (!hold1) m1_valid = en1 && (q1.size() > 0);
    m0_data = (q0.size() > 0) ? q0[0] : 8'h00;
    m1_data = (q1.size() > 0) ? q1[0] : 8'h00;
    wfull = wf;
    @(negedge wrt_clk);
    er0   = (m_own == 0) && !wf;
    er1   = (m_own == 1) && !wf;
    ewe   = (m_own >= 0) && !wf && ((m_own == 0) ? m0_valid : m1_valid);
    ewd   = (m_own == 0) ? m0_data : (m_own == 1) ? m1_data : 8'h00;
    egnt  = (m_own == 1);
    ebusy = (m_own >= 0);
    chk("m0_ready", 32'(m0_ready), 32'(er0));
    chk("m1_ready", 32'(m1_ready), 32'(er1));
    chk("wrt_en", 32'(wrt_en), 32'(ewe));
    chk("wdata", 32'(wdata), 32'(ewd));
    chk("gnt_id", 32'(gnt_id), 32'(egnt));
    chk("busy", 32'(busy), 32'(ebusy));
    chk("wen_while_full", 32'(wrt_en & wfull), 0);
    chk("both_ready", 32'(m0_ready & m1_ready), 0);
    s_wen = wrt_en; s_r1 = m1_ready; s_gnt = gnt_id; s_busy = busy;
    if (wrt_en) begin
      log_id.push_back(int'(gnt_id)); log_dat.push_back(int'(wdata)); log_cyc.push_back(cyc);
      if ((gnt_id ? e1.size() : e0.size()) == 0) chk("sb_extra_beat", 1, 0);
      else begin
        exp_d = gnt_id ? e1.pop_front() : e0.pop_front();
        chk(gnt_id ? "sb_m1" : "sb_m0", 32'(wdata), 32'(exp_d));
      end
    end
    if (m0_valid && m0_ready) begin void'(q0.pop_front()); hold0 = 0; end else hold0 = m0_valid;
    if (m1_valid && m1_ready) begin void'(q1.pop_front()); hold1 = 0; end else hold1 = m1_valid;
    model_step(m0_valid, m1_valid, wf);
    @(posedge wrt_clk); #1;
    cyc++;
  endtask

  task automatic drain(input bit rnd, input int bound);
    int n;
    n = 0;
    while ((e0.size() + e1.size()) > 0 && n < bound) begin
      if (rnd) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 30);
      else     cycle(1'b1, 1'b1, 1'b0);
      n++;
    end
    chk("drain_left", 32'(e0.size() + e1.size()), 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wen"}, 32'(wrt_en), 0);
    chk({tag, "_r0"}, 32'(m0_ready), 0);
    chk({tag, "_r1"}, 32'(m1_ready), 0);
    chk({tag, "_wdata"}, 32'(wdata), 0);
    chk({tag, "_gnt"}, 32'(gnt_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int rem;
    // Reset with requests pending: nothing may leak out
    wrst_n = 1'b0; m0_valid = 1; m1_valid = 1; m0_data = 8'hAA; m1_data = 8'h55;
    model_reset(); clear_all();
    repeat (2) @(posedge wrt_clk);
    @(negedge wrt_clk);
    check_outputs_zero("rst");
    m0_valid = 0; m1_valid = 0; m0_data = 0; m1_data = 0;
    wrst_n = 1'b1;
    @(posedge wrt_clk); #1;

    // Both requesters streaming: first tie to m0, then burst-sized alternation
    for (int i = 0; i < 12; i++) begin push(0, 8'(8'h40 + i)); push(1, 8'(8'h80 + i)); end
    drain(1'b0, 200);
    chk("stream_len", 32'(log_id.size()), 24);
    for (int i = 0; i < 12 && i < log_id.size(); i++) chk("stream_order", 32'(log_id[i]), 32'((i / EBL) % 2));

    // m0 alone, three beats on consecutive cycles after one idle cycle
    clear_all();
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    begin
      int base;
      base = cyc;
      repeat (5) cycle(1'b1, 1'b0, 1'b0);
      chk("solo_len", 32'(log_id.size()), 3);
      for (int i = 0; i < 3 && i < log_id.size(); i++) begin
        chk("solo_id", 32'(log_id[i]), 0);
        chk("solo_cycle", 32'(log_cyc[i] - base), 32'(i + 1));
      end
      if (log_dat.size() == 3) begin
        chk("solo_d0", 32'(log_dat[0]), 32'h11);
        chk("solo_d1", 32'(log_dat[1]), 32'h22);
        chk("solo_d2", 32'(log_dat[2]), 32'h33);
      end
    end

    // wfull for 5 cycles after two m1 beats; m0 appears meanwhile
    clear_all();
    for (int i = 0; i < 8; i++) push(1, 8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) push(0, 8'(8'h30 + i));
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    repeat (5) begin
      cycle(1'b1, 1'b1, 1'b1);
      chk("full_wen", 32'(s_wen), 0);
      chk("full_r1", 32'(s_r1), 0);
      chk("full_owner", 32'(s_gnt), 1);
      chk("full_busy", 32'(s_busy), 1);
    end
    drain(1'b0, 100);
    rem = EBL - (2 % EBL);
    chk("full_len", 32'(log_id.size()), 12);
    if (log_id.size() == 12) begin
      for (int i = 0; i < 2 + rem; i++) chk("full_keep_m1", 32'(log_id[i]), 1);
      chk("full_then_m0", 32'(log_id[2 + rem]), 0);
      chk("full_resume_data", 32'(log_dat[2]), 32'hC2);
    end

    // m0 drops valid after two beats while m1 waits: m1 owns next with a fresh count
    clear_all();
    push(0, 8'h51); push(0, 8'h52);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) push(1, 8'(8'h60 + i));
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(0, 8'(8'h70 + i));
    cycle(1'b1, 1'b1, 1'b0);
    chk("drop_owner", 32'(s_gnt), 1);
    chk("drop_r1", 32'(s_r1), 1);
    drain(1'b0, 100);
    if (log_id.size() == 11) begin
      for (int i = 0; i < EBL; i++) chk("drop_m1_burst", 32'(log_id[2 + i]), 1);
      chk("drop_back_m0", 32'(log_id[2 + EBL]), 0);
    end else chk("drop_len", 32'(log_id.size()), 11);

    // Reset during the second beat of an m1 burst
    clear_all();
    for (int i = 0; i < 8; i++) push(1, 8'(8'hD0 + i));
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    chk("mid_pre_wen", 32'(wrt_en), 1);
    chk("mid_pre_gnt", 32'(gnt_id), 1);
    #2 wrst_n = 1'b0;
    #1 check_outputs_zero("mid_rst");
    model_reset(); clear_all();
    m0_valid = 0; m1_valid = 0;
    @(posedge wrt_clk);
    @(negedge wrt_clk);
    check_outputs_zero("mid_hold");
    wrst_n = 1'b1;
    @(posedge wrt_clk); #1;
    push(0, 8'hE0); push(0, 8'hE1); push(1, 8'hF0); push(1, 8'hF1);
    drain(1'b0, 50);
    if (log_id.size() > 0) chk("post_rst_first", 32'(log_id[0]), 0);
    else chk("post_rst_len", 32'(log_id.size()), 4);

    // Random scoreboard: 1000 beats, random valids and wfull
    clear_all();
    for (int i = 0; i < 1000; i++) push(int'($urandom_range(0, 1)), 8'($urandom));
    drain(1'b1, 20000);
    chk("rand_len", 32'(log_id.size()), 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
